sump_cmd_rx: RTL and testbench

Serial command front end of the logic sniffer, between the external `rx` pin and the SUMP command decoder. It deserialises 8N1 UART at a fixed baud rate and frames SUMP commands. Short commands are one byte with bit 7 = 0. Long commands are one opcode byte with bit 7 = 1 plus four argument bytes. Each complete command goes to the decoder as a single-cycle strobe with opcode and 32-bit argument.

---
 rtl/sump_pkg.sv | 33 +++
 rtl/uart_rx_core.sv | 127 ++++++++++++
 rtl/sump_cmd_rx.sv | 127 ++++++++++++
 tb/tb_sump_cmd_rx.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/sump_pkg.sv
// Shared SUMP constants and types for the serial command front end.
// Opcodes, long-command framing parameters, FSM encodings and a baud divider helper.
`timescale 1ns/1ps
package sump_pkg;

  localparam logic [7:0] OP_RESET          = 8'h00;
  localparam logic [7:0] OP_RUN            = 8'h01;
  localparam logic [7:0] OP_ID             = 8'h02;
  localparam logic [7:0] OP_SET_DIVIDER    = 8'h80;
  localparam logic [7:0] OP_SET_TRIG_MASK0 = 8'hC0;

  localparam int LONG_FLAG_BIT = 7;
  localparam int ARG_BYTES     = 4;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP,
    RX_WAIT_IDLE
  } rx_state_e;

  typedef enum logic {
    FR_OPCODE,
    FR_ARG
  } fr_state_e;

  // Bit period in clock cycles, rounded to nearest.
  function automatic int calc_div(input int clk_freq, input int baud);
    return (clk_freq + baud / 2) / baud;
  endfunction

endpackage

// File: rtl/uart_rx_core.sv
// 8N1 UART receiver: rx synchroniser, bit FSM and baud counter.
// Each byte is timed from its start edge only; bits are sampled mid-period.
`timescale 1ns/1ps
module uart_rx_core
  import sump_pkg::*;
#(
  parameter int CLK_FREQ = 100_000_000,
  parameter int BAUD     = 115200
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       rx,
  output logic       byte_valid,
  output logic [7:0] byte_data,
  output logic       frame_error,
  output logic       busy
);

  localparam int DIV   = calc_div(CLK_FREQ, BAUD);
  localparam int CNT_W = $clog2(DIV);
  // Counter expires on zero, so loads are one less than the wanted interval.
  localparam logic [CNT_W-1:0] HALF_LOAD = CNT_W'(DIV / 2 - 1);
  localparam logic [CNT_W-1:0] BIT_LOAD  = CNT_W'(DIV - 1);

  logic             sync1_q, sync2_q;
  rx_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bit_idx_q, bit_idx_d;
  logic [7:0]       shift_q, shift_d;
  logic             byte_valid_q, byte_valid_d;
  logic             frame_error_q, frame_error_d;

  // NOTE: synchroniser flops reset to idle-high so reset release never looks like a start edge.
  always_ff @(posedge clock) begin
    if (reset) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
    end else begin
      sync1_q <= rx;
      sync2_q <= sync1_q;
    end
  end

  // NOTE: reset is sampled on the clock edge here; every register is cleared, none are left as don't-care.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q       <= RX_IDLE;
      cnt_q         <= '0;
      bit_idx_q     <= '0;
      shift_q       <= '0;
      byte_valid_q  <= 1'b0;
      frame_error_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      bit_idx_q     <= bit_idx_d;
      shift_q       <= shift_d;
      byte_valid_q  <= byte_valid_d;
      frame_error_q <= frame_error_d;
    end
  end

  // NOTE: every signal gets a default before the case so no path can infer a latch.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    bit_idx_d     = bit_idx_q;
    shift_d       = shift_q;
    byte_valid_d  = 1'b0;
    frame_error_d = 1'b0;

    unique case (state_q)
      RX_IDLE: begin
        if (!sync2_q) begin
          cnt_d   = HALF_LOAD;
          state_d = RX_START;
        end
      end
      RX_START: begin
        if (cnt_q == '0) begin
          if (!sync2_q) begin
            cnt_d     = BIT_LOAD;
            bit_idx_d = '0;
            state_d   = RX_DATA;
          end else begin
            state_d = RX_IDLE;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      RX_DATA: begin
        if (cnt_q == '0) begin
          shift_d = {sync2_q, shift_q[7:1]};
          cnt_d   = BIT_LOAD;
          if (bit_idx_q == 3'd7) state_d = RX_STOP;
          else                   bit_idx_d = bit_idx_q + 3'd1;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      RX_STOP: begin
        if (cnt_q == '0) begin
          if (sync2_q) begin
            byte_valid_d = 1'b1;
            state_d      = RX_IDLE;
          end else begin
            frame_error_d = 1'b1;
            state_d       = RX_WAIT_IDLE;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      RX_WAIT_IDLE: begin
        if (sync2_q) state_d = RX_IDLE;
      end
      default: state_d = RX_IDLE;
    endcase
  end

  assign byte_valid  = byte_valid_q;
  assign byte_data   = shift_q;
  assign frame_error = frame_error_q;
  assign busy        = (state_q != RX_IDLE);

endmodule

// File: rtl/sump_cmd_rx.sv
// SUMP command framer: turns received bytes into one-cycle command strobes.
// Long commands carry four little-endian argument bytes and abort on timeout or frame error.
`timescale 1ns/1ps
module sump_cmd_rx
  import sump_pkg::*;
#(
  parameter int CLK_FREQ     = 100_000_000,
  parameter int BAUD         = 115200,
  parameter int TIMEOUT_BITS = 32
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        rx,
  output logic        cmd_valid,
  output logic [7:0]  cmd_opcode,
  output logic [31:0] cmd_data,
  output logic        frame_error,
  output logic        rx_busy
);

  localparam int DIV         = calc_div(CLK_FREQ, BAUD);
  localparam int TIMEOUT_CYC = TIMEOUT_BITS * DIV;
  localparam int GAP_W       = $clog2(TIMEOUT_CYC);

  logic       byte_valid;
  logic [7:0] byte_data;
  logic       core_busy;

  uart_rx_core #(
    .CLK_FREQ(CLK_FREQ),
    .BAUD    (BAUD)
  ) u_core (
    .clock      (clock),
    .reset      (reset),
    .rx         (rx),
    .byte_valid (byte_valid),
    .byte_data  (byte_data),
    .frame_error(frame_error),
    .busy       (core_busy)
  );

  fr_state_e        state_q, state_d;
  logic [1:0]       arg_idx_q, arg_idx_d;
  logic [7:0]       op_pend_q, op_pend_d;
  logic [31:0]      arg_q, arg_d;
  logic [GAP_W-1:0] gap_q, gap_d;
  logic             valid_q, valid_d;
  logic [7:0]       opcode_q, opcode_d;
  logic [31:0]      data_q, data_d;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= FR_OPCODE;
      arg_idx_q <= '0;
      op_pend_q <= '0;
      arg_q     <= '0;
      gap_q     <= '0;
      valid_q   <= 1'b0;
      opcode_q  <= '0;
      data_q    <= '0;
    end else begin
      state_q   <= state_d;
      arg_idx_q <= arg_idx_d;
      op_pend_q <= op_pend_d;
      arg_q     <= arg_d;
      gap_q     <= gap_d;
      valid_q   <= valid_d;
      opcode_q  <= opcode_d;
      data_q    <= data_d;
    end
  end

  // Output opcode/data only change on a strobe; a pending long command lives in op_pend/arg.
  always_comb begin
    state_d   = state_q;
    arg_idx_d = arg_idx_q;
    op_pend_d = op_pend_q;
    arg_d     = arg_q;
    gap_d     = '0;
    valid_d   = 1'b0;
    opcode_d  = opcode_q;
    data_d    = data_q;

    unique case (state_q)
      FR_OPCODE: begin
        if (byte_valid) begin
          if (byte_data[LONG_FLAG_BIT]) begin
            op_pend_d = byte_data;
            arg_d     = '0;
            arg_idx_d = '0;
            state_d   = FR_ARG;
          end else begin
            valid_d  = 1'b1;
            opcode_d = byte_data;
            data_d   = '0;
          end
        end
      end
      FR_ARG: begin
        if (frame_error) begin
          state_d = FR_OPCODE;
        end else if (byte_valid) begin
          arg_d[arg_idx_q*8 +: 8] = byte_data;
          if (arg_idx_q == 2'(ARG_BYTES - 1)) begin
            valid_d  = 1'b1;
            opcode_d = op_pend_q;
            data_d   = arg_d;
            state_d  = FR_OPCODE;
          end else begin
            arg_idx_d = arg_idx_q + 2'd1;
          end
        end else if (gap_q == GAP_W'(TIMEOUT_CYC - 1)) begin
          state_d = FR_OPCODE;
        end else begin
          gap_d = gap_q + 1'b1;
        end
      end
      default: state_d = FR_OPCODE;
    endcase
  end

  assign cmd_valid  = valid_q;
  assign cmd_opcode = opcode_q;
  assign cmd_data   = data_q;
  assign rx_busy    = core_busy || (state_q == FR_ARG);

endmodule

// File: tb/tb_sump_cmd_rx.sv
// Scoreboard bench for sump_cmd_rx: stimulus pushes expected commands, a monitor checks strobes.
`timescale 1ns/1ps
module tb_sump_cmd_rx;

  localparam int BIT_NS = 8680;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        rx    = 1'b1;
  logic        cmd_valid;
  logic [7:0]  cmd_opcode;
  logic [31:0] cmd_data;
  logic        frame_error;
  logic        rx_busy;

  sump_cmd_rx dut (
    .clock      (clock),
    .reset      (reset),
    .rx         (rx),
    .cmd_valid  (cmd_valid),
    .cmd_opcode (cmd_opcode),
    .cmd_data   (cmd_data),
    .frame_error(frame_error),
    .rx_busy    (rx_busy)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [7:0]  op;
    logic [31:0] data;
  } exp_t;

  exp_t exp_q[$];
  int   n_vec   = 0;
  int   n_miss  = 0;
  int   strobes = 0;
  int   fe_cnt  = 0;
  time  t_valid = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  always @(negedge clock) begin
    if (!reset) begin
      if (frame_error) fe_cnt++;
      if (cmd_valid) begin
        exp_t e;
        strobes++;
        t_valid = $time;
        if (exp_q.size() == 0) begin
          n_vec++;
          n_miss++;
          $display("FAIL unexpected_strobe: got opcode %h data %h, expected no strobe",
                   cmd_opcode, cmd_data);
        end else begin
          e = exp_q.pop_front();
          check("cmd_opcode", {24'h0, cmd_opcode}, {24'h0, e.op});
          check("cmd_data", cmd_data, e.data);
        end
      end
    end
  end

  task automatic send_byte(input logic [7:0] b, input logic stop_bit = 1'b1);
    rx = 1'b0;
    #BIT_NS;
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      #BIT_NS;
    end
    rx = stop_bit;
    #BIT_NS;
    rx = 1'b1;
  endtask

  task automatic expect_cmd(input logic [7:0] op, input logic [31:0] data);
    exp_t e;
    e.op   = op;
    e.data = data;
    exp_q.push_back(e);
  endtask

  task automatic wait_drain(input string name, input int budget);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(negedge clock);
      n++;
    end
    if (exp_q.size() != 0) begin
      n_vec++;
      n_miss++;
      $display("FAIL %s: got %0d outstanding strobes, expected 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  initial begin
    int  s, f, lat;
    time t_start;

    repeat (5) @(posedge clock);
    #1 reset = 1'b0;
    @(negedge clock);
    check("reset_cmd_valid", {31'h0, cmd_valid}, 32'h0);
    check("reset_cmd_opcode", {24'h0, cmd_opcode}, 32'h0);
    check("reset_cmd_data", cmd_data, 32'h0);
    check("reset_frame_error", {31'h0, frame_error}, 32'h0);
    check("reset_rx_busy", {31'h0, rx_busy}, 32'h0);

    // Short command and latency from start edge.
    expect_cmd(8'h02, 32'h0);
    t_start = $time;
    send_byte(8'h02);
    wait_drain("short_0x02", 2000);
    lat = int'((t_valid - t_start) / 10);
    check("latency_cycles", (lat >= 8247 && lat <= 8251) ? 32'd8249 : lat, 32'd8249);
    #(2 * BIT_NS);

    // Long command: strobe only after the fifth byte.
    s = strobes;
    expect_cmd(8'hC0, 32'h1234_5678);
    send_byte(8'hC0);
    check("busy_in_arg", {31'h0, rx_busy}, 32'h1);
    send_byte(8'h78);
    send_byte(8'h56);
    send_byte(8'h34);
    check("no_strobe_bytes1_4", strobes, s);
    send_byte(8'h12);
    wait_drain("long_0xC0", 2000);
    check("one_strobe_long", strobes, s + 1);
    #(2 * BIT_NS);

    // Frame error then recovery.
    s = strobes;
    f = fe_cnt;
    send_byte(8'h01, 1'b0);
    #(2 * BIT_NS);
    check("frame_error_pulses", fe_cnt, f + 1);
    check("no_strobe_on_ferr", strobes, s);
    expect_cmd(8'h00, 32'h0);
    send_byte(8'h00);
    wait_drain("after_ferr_0x00", 2000);
    #(2 * BIT_NS);

    // Partial long command abandoned by inter-byte timeout.
    s = strobes;
    send_byte(8'h80);
    send_byte(8'hAA);
    #(40 * BIT_NS);
    check("no_strobe_timeout", strobes, s);
    check("idle_after_timeout", {31'h0, rx_busy}, 32'h0);
    expect_cmd(8'h02, 32'h0);
    send_byte(8'h02);
    wait_drain("after_timeout_0x02", 2000);
    #(2 * BIT_NS);

    // False start glitch.
    s = strobes;
    f = fe_cnt;
    rx = 1'b0;
    repeat (200) @(posedge clock);
    rx = 1'b1;
    repeat (1000) @(posedge clock);
    @(negedge clock);
    check("false_start_busy", {31'h0, rx_busy}, 32'h0);
    check("false_start_strobes", strobes, s);
    check("false_start_ferr", fe_cnt, f);

    // Reset midway through the third argument byte (0x33).
    s = strobes;
    send_byte(8'hC0);
    send_byte(8'h11);
    send_byte(8'h22);
    rx = 1'b0;
    #BIT_NS;
    rx = 1'b1;
    #BIT_NS;
    rx = 1'b1;
    #BIT_NS;
    rx = 1'b0;
    #(BIT_NS / 2);
    @(posedge clock);
    #1 reset = 1'b1;
    rx = 1'b1;
    repeat (4) @(posedge clock);
    @(negedge clock);
    check("rst_mid_cmd_valid", {31'h0, cmd_valid}, 32'h0);
    check("rst_mid_cmd_opcode", {24'h0, cmd_opcode}, 32'h0);
    check("rst_mid_cmd_data", cmd_data, 32'h0);
    check("rst_mid_frame_error", {31'h0, frame_error}, 32'h0);
    check("rst_mid_rx_busy", {31'h0, rx_busy}, 32'h0);
    @(posedge clock);
    #1 reset = 1'b0;
    #(20 * BIT_NS);
    check("rst_mid_no_strobe", strobes, s);
    expect_cmd(8'h01, 32'h0);
    send_byte(8'h01);
    wait_drain("after_reset_0x01", 2000);
    #(2 * BIT_NS);
    check("final_queue_empty", exp_q.size(), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
